// File: rtl/psum_accum.sv
// Partial-sum accumulator: sums signed products over an in_last-delimited group,
// then rounds, shifts and saturates the sum into a 2-entry valid/ready output buffer.
module psum_accum #(
    parameter int DATA_WID   = 16,
    parameter int ACC_WID    = 40,
    parameter int OUT_WID    = 16,
    parameter int FRAC_SHIFT = 8,
    parameter int CNT_WID    = 8
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [2*DATA_WID-1:0] psum_in,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic [OUT_WID-1:0]    out_data,
    output logic                  out_sat,
    output logic [CNT_WID-1:0]    out_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_drop
);

    localparam int RW = ACC_WID + 1;
    localparam logic signed [RW-1:0] HALF    = RW'(64'sd1 <<< (FRAC_SHIFT - 1));
    localparam logic signed [RW-1:0] OUT_MAX = RW'((64'sd1 <<< (OUT_WID - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] OUT_MIN = -OUT_MAX - RW'(1);

    typedef enum logic {IDLE, ACCUM} state_t;

    typedef struct packed {
        logic [OUT_WID-1:0] data;
        logic               sat;
        logic [CNT_WID-1:0] len;
    } entry_t;

    state_t                    state_q, state_d;
    logic signed [ACC_WID-1:0] acc_q, acc_d;
    logic        [CNT_WID-1:0] cnt_q, cnt_d;

    logic signed [ACC_WID-1:0] psum_ext;
    logic signed [ACC_WID-1:0] acc_sum;
    logic        [CNT_WID-1:0] cnt_sum;
    logic signed [RW-1:0]      rnd_w;
    logic signed [RW-1:0]      shr_w;
    entry_t                    new_entry;

    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       err_q, err_d;
    logic       push;
    logic       pop;

    // The first beat of a group replaces the accumulator rather than adding to it.
    always_comb begin
        psum_ext = ACC_WID'($signed(psum_in));
        acc_sum  = (state_q == IDLE) ? psum_ext : acc_q + psum_ext;
        if (state_q == IDLE)
            cnt_sum = CNT_WID'(1);
        else if (&cnt_q)
            cnt_sum = cnt_q;
        else
            cnt_sum = cnt_q + CNT_WID'(1);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (in_valid) begin
            acc_d   = acc_sum;
            cnt_d   = cnt_sum;
            state_d = in_last ? IDLE : ACCUM;
        end
    end

    // One extra bit of headroom so the rounding offset can never overflow.
    always_comb begin
        rnd_w          = RW'(acc_sum) + HALF;
        shr_w          = rnd_w >>> FRAC_SHIFT;
        new_entry.len  = cnt_sum;
        new_entry.sat  = 1'b0;
        new_entry.data = OUT_WID'(shr_w);
        if (shr_w > OUT_MAX) begin
            new_entry.data = OUT_WID'(OUT_MAX);
            new_entry.sat  = 1'b1;
        end else if (shr_w < OUT_MIN) begin
            new_entry.data = OUT_WID'(OUT_MIN);
            new_entry.sat  = 1'b1;
        end
    end

    assign push      = in_valid & in_last;
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid & out_ready;

    // Head lives in its own register so outputs hold the last head value when empty.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = new_entry;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = new_entry;
                end else if (push) begin
                    tail_d  = new_entry;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (push && pop) begin
                    head_d = tail_q;
                    tail_d = new_entry;
                end else if (push) begin
                    err_d = 1'b1;
                end else if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            err_q   <= 1'b0;
        end else if (clr) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            count_q <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign out_data = head_q.data;
    assign out_sat  = head_q.sat;
    assign out_len  = head_q.len;
    assign err_drop = err_q;

endmodule

// File: tb/tb_psum_accum.sv
// Scenario bench for psum_accum: expected group results are queued when the last
// beat is driven and compared when they reach the buffer head.
module tb_psum_accum;

    typedef struct packed {
        logic [15:0] data;
        logic        sat;
        logic [7:0]  len;
    } exp_t;

    logic        clock = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic [31:0] psum_in = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] out_data;
    logic        out_sat;
    logic [7:0]  out_len;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        err_drop;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clock = ~clock;

    psum_accum #(
        .DATA_WID(16), .ACC_WID(40), .OUT_WID(16), .FRAC_SHIFT(8), .CNT_WID(8)
    ) dut (
        .clock(clock), .rst_n(rst_n), .clr(clr),
        .psum_in(psum_in), .in_valid(in_valid), .in_last(in_last),
        .out_data(out_data), .out_sat(out_sat), .out_len(out_len),
        .out_valid(out_valid), .out_ready(out_ready), .err_drop(err_drop)
    );

    function automatic exp_t mk(input logic [15:0] d, input logic s, input logic [7:0] l);
        exp_t e;
        e.data = d;
        e.sat  = s;
        e.len  = l;
        return e;
    endfunction

    // Reference: round half up, arithmetic shift by 8, clamp to 16-bit signed.
    function automatic exp_t model(input longint sum, input int len);
        longint r;
        r = (sum + 64'sd128) >>> 8;
        if (r > 64'sd32767)       return mk(16'h7FFF, 1'b1, 8'(len));
        else if (r < -64'sd32768) return mk(16'h8000, 1'b1, 8'(len));
        else                      return mk(16'(r), 1'b0, 8'(len));
    endfunction

    task automatic beat(input logic [31:0] d, input logic last);
        psum_in  = d;
        in_valid = 1'b1;
        in_last  = last;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sat !== 1'b0 || out_len !== 8'h0 || err_drop !== 1'b0)
            $display("FAIL reset_state: got v=%b d=%h s=%b l=%0d e=%b, want all zero",
                     out_valid, out_data, out_sat, out_len, err_drop);
        else pass_cnt++;
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        exp_t e;
        out_ready = 1'b1;
        beat(32'd256, 1'b0);
        beat(32'd512, 1'b0);
        sb.push_back(mk(16'd6, 1'b0, 8'd3));
        beat(32'd768, 1'b1);
        @(negedge clock);
        e = sb.pop_front();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== e.data || out_sat !== e.sat || out_len !== e.len)
            $display("FAIL basic_head: got v=%b d=%h s=%b l=%0d, want v=1 d=%h s=%b l=%0d",
                     out_valid, out_data, out_sat, out_len, e.data, e.sat, e.len);
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL basic_drained: got v=%b, want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_rounding();
        exp_t e;
        out_ready = 1'b1;
        sb.push_back(mk(16'd2, 1'b0, 8'd1));
        beat(32'd384, 1'b1);
        @(negedge clock);
        e = sb.pop_front();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== e.data || out_sat !== e.sat || out_len !== e.len)
            $display("FAIL round_pos: got v=%b d=%h s=%b l=%0d, want v=1 d=%h s=%b l=%0d",
                     out_valid, out_data, out_sat, out_len, e.data, e.sat, e.len);
        else pass_cnt++;
        sb.push_back(mk(16'hFFFF, 1'b0, 8'd1));
        beat(32'hFFFF_FE80, 1'b1);
        @(negedge clock);
        e = sb.pop_front();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== e.data || out_sat !== e.sat || out_len !== e.len)
            $display("FAIL round_neg: got v=%b d=%h s=%b l=%0d, want v=1 d=%h s=%b l=%0d",
                     out_valid, out_data, out_sat, out_len, e.data, e.sat, e.len);
        else pass_cnt++;
        @(negedge clock);
    endtask

    task automatic test_saturation();
        exp_t e;
        out_ready = 1'b1;
        beat(32'h4000_0000, 1'b0);
        sb.push_back(mk(16'h7FFF, 1'b1, 8'd2));
        beat(32'h4000_0000, 1'b1);
        @(negedge clock);
        e = sb.pop_front();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== e.data || out_sat !== e.sat || out_len !== e.len)
            $display("FAIL sat_pos: got v=%b d=%h s=%b l=%0d, want v=1 d=%h s=%b l=%0d",
                     out_valid, out_data, out_sat, out_len, e.data, e.sat, e.len);
        else pass_cnt++;
        beat(32'h8000_0000, 1'b0);
        sb.push_back(mk(16'h8000, 1'b1, 8'd2));
        beat(32'h8000_0000, 1'b1);
        @(negedge clock);
        e = sb.pop_front();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== e.data || out_sat !== e.sat || out_len !== e.len)
            $display("FAIL sat_neg: got v=%b d=%h s=%b l=%0d, want v=1 d=%h s=%b l=%0d",
                     out_valid, out_data, out_sat, out_len, e.data, e.sat, e.len);
        else pass_cnt++;
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        exp_t e;
        out_ready = 1'b0;
        sb.push_back(mk(16'd1, 1'b0, 8'd1));
        beat(32'd256, 1'b1);
        sb.push_back(mk(16'd2, 1'b0, 8'd1));
        beat(32'd512, 1'b1);
        beat(32'd768, 1'b1);
        @(negedge clock);
        total_cnt++;
        if (err_drop !== 1'b1) $display("FAIL drop_flag: got err_drop=%b, want 1", err_drop);
        else pass_cnt++;
        e = sb.pop_front();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== e.data || out_len !== e.len)
            $display("FAIL bp_first: got v=%b d=%h l=%0d, want v=1 d=%h l=%0d",
                     out_valid, out_data, out_len, e.data, e.len);
        else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clock);
        e = sb.pop_front();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== e.data || out_len !== e.len)
            $display("FAIL bp_second: got v=%b d=%h l=%0d, want v=1 d=%h l=%0d",
                     out_valid, out_data, out_len, e.data, e.len);
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if (out_valid !== 1'b0 || err_drop !== 1'b1)
            $display("FAIL bp_empty_sticky: got v=%b e=%b, want v=0 e=1", out_valid, err_drop);
        else pass_cnt++;
        clr = 1'b1;
        @(posedge clock);
        #1 clr = 1'b0;
        @(negedge clock);
        total_cnt++;
        if (err_drop !== 1'b0) $display("FAIL clr_err: got err_drop=%b, want 0", err_drop);
        else pass_cnt++;
    endtask

    task automatic test_full_pop();
        exp_t e;
        out_ready = 1'b0;
        sb.push_back(mk(16'd1, 1'b0, 8'd1));
        beat(32'd256, 1'b1);
        sb.push_back(mk(16'd2, 1'b0, 8'd1));
        beat(32'd512, 1'b1);
        @(negedge clock);
        e = sb.pop_front();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== e.data)
            $display("FAIL full_head1: got v=%b d=%h, want v=1 d=%h", out_valid, out_data, e.data);
        else pass_cnt++;
        out_ready = 1'b1;
        sb.push_back(mk(16'd3, 1'b0, 8'd1));
        beat(32'd768, 1'b1);
        @(negedge clock);
        e = sb.pop_front();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== e.data || err_drop !== 1'b0)
            $display("FAIL full_head2: got v=%b d=%h e=%b, want v=1 d=%h e=0",
                     out_valid, out_data, err_drop, e.data);
        else pass_cnt++;
        @(negedge clock);
        e = sb.pop_front();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== e.data)
            $display("FAIL full_head3: got v=%b d=%h, want v=1 d=%h", out_valid, out_data, e.data);
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if (out_valid !== 1'b0 || err_drop !== 1'b0)
            $display("FAIL full_drained: got v=%b e=%b, want v=0 e=0", out_valid, err_drop);
        else pass_cnt++;
    endtask

    task automatic test_midgroup_abort();
        exp_t e;
        out_ready = 1'b1;
        beat(32'd1000, 1'b0);
        beat(32'd1000, 1'b0);
        @(negedge clock);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sat !== 1'b0 || out_len !== 8'h0 || err_drop !== 1'b0)
            $display("FAIL midreset_zero: got v=%b d=%h s=%b l=%0d e=%b, want all zero",
                     out_valid, out_data, out_sat, out_len, err_drop);
        else pass_cnt++;
        @(negedge clock);
        rst_n = 1'b1;
        sb.push_back(mk(16'd1, 1'b0, 8'd1));
        beat(32'd256, 1'b1);
        @(negedge clock);
        e = sb.pop_front();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== e.data || out_len !== e.len)
            $display("FAIL midreset_next: got v=%b d=%h l=%0d, want v=1 d=%h l=%0d",
                     out_valid, out_data, out_len, e.data, e.len);
        else pass_cnt++;
        beat(32'd1000, 1'b0);
        beat(32'd1000, 1'b0);
        clr = 1'b1;
        @(posedge clock);
        #1 clr = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL midclr_empty: got v=%b, want 0", out_valid);
        else pass_cnt++;
        sb.push_back(mk(16'd1, 1'b0, 8'd1));
        beat(32'd256, 1'b1);
        @(negedge clock);
        e = sb.pop_front();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== e.data || out_len !== e.len)
            $display("FAIL midclr_next: got v=%b d=%h l=%0d, want v=1 d=%h l=%0d",
                     out_valid, out_data, out_len, e.data, e.len);
        else pass_cnt++;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        int n_groups;
        int got;
        exp_t e;
        n_groups  = 12;
        got       = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int g = 0; g < n_groups; g++) begin
                    int     len;
                    longint sum;
                    len = int'($urandom_range(1, 5));
                    sum = 0;
                    for (int b = 0; b < len; b++) begin
                        int v;
                        v = int'($urandom_range(0, 33554432)) - 16777216;
                        sum += longint'(v);
                        if (b == len - 1) begin
                            sb.push_back(model(sum, len));
                            beat(32'(v), 1'b1);
                        end else begin
                            beat(32'(v), 1'b0);
                        end
                    end
                end
            end
            begin
                for (int cyc = 0; cyc < 300 && got < n_groups; cyc++) begin
                    @(negedge clock);
                    if (out_valid === 1'b1) begin
                        total_cnt++;
                        if (sb.size() == 0) begin
                            $display("FAIL b2b_extra: got unexpected result d=%h", out_data);
                        end else begin
                            e = sb.pop_front();
                            if (out_data !== e.data || out_sat !== e.sat || out_len !== e.len)
                                $display("FAIL b2b_result%0d: got d=%h s=%b l=%0d, want d=%h s=%b l=%0d",
                                         got, out_data, out_sat, out_len, e.data, e.sat, e.len);
                            else pass_cnt++;
                        end
                        got++;
                    end
                end
            end
        join
        total_cnt++;
        if (got != n_groups) $display("FAIL b2b_count: got %0d results, want %0d", got, n_groups);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_full_pop();
        test_midgroup_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
